// File: rtl/fpu_result_encode.sv
// Final IEEE-754 single result encoder: NaN/invalid/div-zero/inf substitution and flags.
// Ports: in_valid/in_ready beat in, class flags+operands+core result, out_valid/out_ready result, sticky flags.
module fpu_result_encode #(
  parameter logic [31:0] QNAN_DEF = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fpu_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        opa_nan,
  input  logic        opb_nan,
  input  logic        opa_inf,
  input  logic        opb_inf,
  input  logic        opa_00,
  input  logic        opb_00,
  input  logic [31:0] core_res,
  input  logic        core_ovf,
  input  logic        core_unf,
  input  logic        core_inx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [4:0]  out_flags,
  input  logic        flag_clr,
  output logic [4:0]  sticky_flags
);

  typedef enum logic [2:0] {
    C_NRM = 3'd0,
    C_NAN = 3'd1,
    C_INV = 3'd2,
    C_DZ  = 3'd3,
    C_INF = 3'd4
  } case_e;

  logic        en;
  logic        is_add, is_sub, is_mul, is_div;
  logic        both_inf, sgn_ne, inv, dz;
  case_e       case_d;

  logic        s1_valid_q;
  logic [1:0]  s1_op_q;
  case_e       s1_case_q;
  logic [31:0] s1_opa_q, s1_opb_q, s1_core_q;
  logic        s1_anan_q, s1_bnan_q, s1_ainf_q;
  logic        s1_ovf_q, s1_unf_q, s1_inx_q;

  logic        out_valid_q;
  logic [31:0] res_q, res_d;
  logic [4:0]  flags_q, flags_d;
  logic [4:0]  sticky_q, sticky_d;
  logic        sx, snan;

  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;

  assign is_add   = (fpu_op == 2'b00);
  assign is_sub   = (fpu_op == 2'b01);
  assign is_mul   = (fpu_op == 2'b10);
  assign is_div   = (fpu_op == 2'b11);
  assign both_inf = opa_inf & opb_inf;
  assign sgn_ne   = opa[31] ^ opb[31];

  assign inv = (is_add & both_inf & sgn_ne)
             | (is_sub & both_inf & ~sgn_ne)
             | (is_mul & ((opa_inf & opb_00) | (opb_inf & opa_00)))
             | (is_div & ((opa_00 & opb_00) | both_inf));
  assign dz  = is_div & opb_00 & ~opa_inf & ~opa_00;

  // Priority order: NaN, invalid, div-by-zero, infinity, normal
  always_comb begin
    case_d = C_NRM;
    if (opa_nan | opb_nan)       case_d = C_NAN;
    else if (inv)                case_d = C_INV;
    else if (dz)                 case_d = C_DZ;
    else if (opa_inf | opb_inf)  case_d = C_INF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 2'b00;
      s1_case_q  <= C_NRM;
      s1_opa_q   <= '0;
      s1_opb_q   <= '0;
      s1_core_q  <= '0;
      s1_anan_q  <= 1'b0;
      s1_bnan_q  <= 1'b0;
      s1_ainf_q  <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_unf_q   <= 1'b0;
      s1_inx_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_op_q    <= fpu_op;
      s1_case_q  <= case_d;
      s1_opa_q   <= opa;
      s1_opb_q   <= opb;
      s1_core_q  <= core_res;
      s1_anan_q  <= opa_nan;
      s1_bnan_q  <= opb_nan;
      s1_ainf_q  <= opa_inf;
      s1_ovf_q   <= core_ovf;
      s1_unf_q   <= core_unf;
      s1_inx_q   <= core_inx;
    end
  end

  assign sx   = s1_opa_q[31] ^ s1_opb_q[31];
  assign snan = (s1_anan_q & ~s1_opa_q[22])
              | (s1_bnan_q & ~s1_opb_q[22]);

  always_comb begin
    res_d   = s1_core_q;
    flags_d = {2'b00, s1_ovf_q, s1_unf_q,
               s1_inx_q | s1_ovf_q};
    unique case (s1_case_q)
      C_NAN: begin
        res_d     = s1_anan_q ? s1_opa_q : s1_opb_q;
        res_d[22] = 1'b1;
        flags_d   = {snan, 4'b0000};
      end
      C_INV: begin
        res_d   = QNAN_DEF;
        flags_d = 5'b10000;
      end
      C_DZ: begin
        res_d   = {sx, 8'hFF, 23'h0};
        flags_d = 5'b01000;
      end
      C_INF: begin
        flags_d = 5'b00000;
        if (!s1_op_q[1])
          // add/sub: pass the infinite operand, subtrahend negated
          res_d = s1_ainf_q ? s1_opa_q
                : {s1_opb_q[31] ^ s1_op_q[0], s1_opb_q[30:0]};
        else if (!s1_op_q[0] || s1_ainf_q)
          res_d = {sx, 8'hFF, 23'h0};
        else
          res_d = {sx, 31'h0};
      end
      default: ;
    endcase
  end

  assign sticky_d = (flag_clr ? 5'b0 : sticky_q)
                  | ((out_valid_q & out_ready) ? flags_q : 5'b0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      sticky_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q   <= res_d;
          flags_q <= flags_d;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_res      = res_q;
  assign out_flags    = flags_q;
  assign sticky_flags = sticky_q;

endmodule
